// File: rtl/rr_mux_arbiter_if.sv
// Bus bundle for rr_mux_arbiter: four requester data words, request/lock inputs,
// and the registered grant/select/data/valid outputs with the consumer's ready.
interface rr_mux_arbiter_if #(
  parameter int unsigned WIDTH = 4
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  logic [WIDTH-1:0] d;
  logic [3:0]       req;
  logic             y_ready;
  logic             lock;
  logic [3:0]       grant;
  logic [1:0]       sel;
  logic [WIDTH-1:0] y;
  logic             y_valid;

  // Producers and consumer side.
  modport master (
    output a, b, c, d, req, y_ready, lock,
    input  grant, sel, y, y_valid
  );

  // Arbiter side.
  modport slave (
    input  a, b, c, d, req, y_ready, lock,
    output grant, sel, y, y_valid
  );
endinterface

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter sharing a 4:1 mux among four requesters, with a registered
// valid/ready output. Define ARB_LOCK_EN to let lock re-grant the current owner.
module rr_mux_arbiter #(
  parameter int unsigned WIDTH = 4
) (
  input logic             clk,
  input logic             rst_n,
  rr_mux_arbiter_if.slave bus
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0]       state_q;
  logic [1:0]       ptr_q;
  logic [1:0]       sel_q;
  logic [3:0]       grant_q;
  logic [WIDTH-1:0] y_q;

  logic [3:0]       elig;
  logic [1:0]       rr_win;
  logic             rr_found;
  logic             lock_hit;
  logic [1:0]       pick;
  logic             capture;
  logic [WIDTH-1:0] pick_data;

  // A requester whose grant pulse is still high is skipped this edge.
  assign elig = bus.req & ~grant_q;

  always_comb begin
    logic [1:0] idx;
    rr_win   = ptr_q;
    rr_found = 1'b0;
    idx      = ptr_q;
    for (int i = 0; i < 4; i++) begin
      idx = ptr_q + 2'(i);
      if (!rr_found && elig[idx]) begin
        rr_win   = idx;
        rr_found = 1'b1;
      end
    end
  end

`ifdef ARB_LOCK_EN
  assign lock_hit = bus.lock & bus.req[sel_q];
`else
  assign lock_hit = bus.lock & 1'b0;
`endif

  assign pick    = lock_hit ? sel_q : rr_win;
  assign capture = (lock_hit | rr_found) & ((state_q == IDLE) | bus.y_ready);

  always_comb begin
    pick_data = bus.a;
    unique case (pick)
      2'd0: pick_data = bus.a;
      2'd1: pick_data = bus.b;
      2'd2: pick_data = bus.c;
      2'd3: pick_data = bus.d;
      default: pick_data = bus.a;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      sel_q   <= 2'd0;
      grant_q <= 4'b0000;
      y_q     <= '0;
    end else if (capture) begin
      state_q <= BUSY;
      sel_q   <= pick;
      grant_q <= 4'b0001 << pick;
      y_q     <= pick_data;
      if (!lock_hit) begin
        ptr_q <= pick + 2'd1;
      end
    end else begin
      grant_q <= 4'b0000;
      if (state_q == BUSY && bus.y_ready) begin
        state_q <= IDLE;
      end
    end
  end

  assign bus.grant   = grant_q;
  assign bus.sel     = sel_q;
  assign bus.y       = y_q;
  assign bus.y_valid = (state_q == BUSY);

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed, table-driven bench for rr_mux_arbiter plus hand-written reset and lock sequences.
module tb_rr_mux_arbiter;

  localparam logic [3:0] DA = 4'hA;
  localparam logic [3:0] DB = 4'hB;
  localparam logic [3:0] DC = 4'hC;
  localparam logic [3:0] DD = 4'hD;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  rr_mux_arbiter_if #(.WIDTH(4)) bus ();

  rr_mux_arbiter #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       rdy;
    logic [3:0] cdat;
    logic [3:0] ey;
    logic [1:0] esel;
    logic [3:0] eg;
    logic       ev;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic rst, input logic [3:0] req, input logic rdy,
                     input logic [3:0] cdat, input logic [3:0] ey, input logic [1:0] esel,
                     input logic [3:0] eg, input logic ev);
    vec_t v;
    v.rst = rst; v.req = req; v.rdy = rdy; v.cdat = cdat;
    v.ey = ey; v.esel = esel; v.eg = eg; v.ev = ev;
    vq.push_back(v);
  endtask

  task automatic chk(input string nm, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  task automatic chk_all(input int idx, input logic [3:0] ey, input logic [1:0] esel,
                         input logic [3:0] eg, input logic ev);
    chk("y", idx, 32'(bus.y), 32'(ey));
    chk("sel", idx, 32'(bus.sel), 32'(esel));
    chk("grant", idx, 32'(bus.grant), 32'(eg));
    chk("y_valid", idx, 32'(bus.y_valid), 32'(ev));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    bus.req = 4'b0000;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    errors      = 0;
    checks      = 0;
    rst_n       = 1'b0;
    bus.a       = DA;
    bus.b       = DB;
    bus.c       = DC;
    bus.d       = DD;
    bus.req     = 4'b1111;
    bus.y_ready = 1'b1;
    bus.lock    = 1'b0;

    // Reset held with all requests asserted.
    step();
    step();
    chk_all(100, 4'h0, 2'd0, 4'b0000, 1'b0);
    bus.req = 4'b0000;
    rst_n   = 1'b1;
    step();
    chk_all(101, 4'h0, 2'd0, 4'b0000, 1'b0);

    //  rst  req      rdy   c    y   sel  grant    valid
    add(0, 4'b0010, 1'b1, DC, DB, 2'd1, 4'b0010, 1'b1);
    add(0, 4'b0000, 1'b1, DC, DB, 2'd1, 4'b0000, 1'b0);
    add(1, 4'b1111, 1'b1, DC, DA, 2'd0, 4'b0001, 1'b1);
    add(0, 4'b1111, 1'b1, DC, DB, 2'd1, 4'b0010, 1'b1);
    add(0, 4'b1111, 1'b1, DC, DC, 2'd2, 4'b0100, 1'b1);
    add(0, 4'b1111, 1'b1, DC, DD, 2'd3, 4'b1000, 1'b1);
    add(0, 4'b1111, 1'b1, DC, DA, 2'd0, 4'b0001, 1'b1);
    add(0, 4'b1111, 1'b1, DC, DB, 2'd1, 4'b0010, 1'b1);
    add(0, 4'b1111, 1'b1, DC, DC, 2'd2, 4'b0100, 1'b1);
    add(0, 4'b1011, 1'b0, 4'h5, DC, 2'd2, 4'b0000, 1'b1);
    add(0, 4'b1011, 1'b0, 4'h5, DC, 2'd2, 4'b0000, 1'b1);
    add(0, 4'b1011, 1'b0, 4'h5, DC, 2'd2, 4'b0000, 1'b1);
    add(0, 4'b1011, 1'b1, 4'h5, DD, 2'd3, 4'b1000, 1'b1);

    foreach (vq[i]) begin
      if (vq[i].rst) do_reset();
      bus.req     = vq[i].req;
      bus.y_ready = vq[i].rdy;
      bus.c       = vq[i].cdat;
      step();
      chk_all(i, vq[i].ey, vq[i].esel, vq[i].eg, vq[i].ev);
    end

    // Asynchronous reset between edges while holding d.
    #2 rst_n = 1'b0;
    #1;
    chk_all(200, 4'h0, 2'd0, 4'b0000, 1'b0);
    #1 rst_n = 1'b1;
    bus.c       = DC;
    bus.req     = 4'b1010;
    bus.y_ready = 1'b1;
    step();
    chk_all(201, DB, 2'd1, 4'b0010, 1'b1);
    step();
    chk_all(202, DD, 2'd3, 4'b1000, 1'b1);

    // Lock sequence: re-grants a when enabled, plain rotation otherwise.
    do_reset();
    bus.req  = 4'b1111;
    bus.lock = 1'b0;
    step();
    chk_all(300, DA, 2'd0, 4'b0001, 1'b1);
    bus.lock = 1'b1;
    step();
`ifdef ARB_LOCK_EN
    chk_all(301, DA, 2'd0, 4'b0001, 1'b1);
`else
    chk_all(301, DB, 2'd1, 4'b0010, 1'b1);
`endif
    step();
`ifdef ARB_LOCK_EN
    chk_all(302, DA, 2'd0, 4'b0001, 1'b1);
`else
    chk_all(302, DC, 2'd2, 4'b0100, 1'b1);
`endif
    bus.lock = 1'b0;
    step();
`ifdef ARB_LOCK_EN
    chk_all(303, DB, 2'd1, 4'b0010, 1'b1);
`else
    chk_all(303, DD, 2'd3, 4'b1000, 1'b1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
